// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Definitions shared by the price packet parser and trade_strategy.
//   PRICE_W            : width of one exchange price, in cents
//   SYNC_BYTE_DEFAULT  : default packet start marker
//   parser_state_t     : parser FSM state encoding (6 states, 3 bits)
//   trade_action_t     : action codes emitted by trade_strategy
//   chk_fold()         : running XOR used to build the packet checksum
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int           PRICE_W           = 16;
    localparam logic [7:0]   SYNC_BYTE_DEFAULT = 8'hAA;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_A_HI = 3'd1,
        ST_A_LO = 3'd2,
        ST_B_HI = 3'd3,
        ST_B_LO = 3'd4,
        ST_CHK  = 3'd5
    } parser_state_t;

    typedef enum logic [1:0] {
        NO_TRADE     = 2'b00,
        BUY_A_SELL_B = 2'b01,
        BUY_B_SELL_A = 2'b10
    } trade_action_t;

    // The checksum covers the four price bytes only; the sync byte is excluded.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/price_packet_parser_if.sv
// -----------------------------------------------------------------------------
// price_packet_parser_if
// Bundles the UART byte stream going into the parser and the validated price
// outputs going to trade_strategy.
//   rx_data/rx_valid      : byte stream from the UART receiver
//   price_A/price_B       : last validated prices, in cents
//   packet_valid          : one-cycle pulse, prices just updated
//   err_checksum          : one-cycle pulse, checksum mismatch
//   err_timeout           : one-cycle pulse, inter-byte timeout
//   pkt_count             : count of good packets (wraps)
// modport master : the side producing bytes and consuming prices
// modport slave  : the parser
// -----------------------------------------------------------------------------
interface price_packet_parser_if;
    import arb_pkg::*;

    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [PRICE_W-1:0] price_A;
    logic [PRICE_W-1:0] price_B;
    logic               packet_valid;
    logic               err_checksum;
    logic               err_timeout;
    logic [15:0]        pkt_count;

    modport master (
        output rx_data, rx_valid,
        input  price_A, price_B, packet_valid, err_checksum, err_timeout, pkt_count
    );

    modport slave (
        input  rx_data, rx_valid,
        output price_A, price_B, packet_valid, err_checksum, err_timeout, pkt_count
    );

endinterface

// File: rtl/byte_timeout_timer.sv
// -----------------------------------------------------------------------------
// byte_timeout_timer
// Counts idle cycles between bytes of a packet and flags when the gap has
// reached TIMEOUT_CYCLES.
//   clk, rst   : clock, asynchronous active-high reset
//   i_enable   : count while high (packet in progress); held at 0 when low
//   i_clear    : a byte was accepted this cycle; restart the count
//   o_expired  : single-cycle flag, gap limit reached with no byte this cycle
// -----------------------------------------------------------------------------
module byte_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
    // A byte arriving on the limit cycle wins, so clear masks the expiry.
    assign o_expired  = i_enable & ~i_clear & w_at_limit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!i_enable || i_clear || o_expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/price_packet_parser.sv
// -----------------------------------------------------------------------------
// price_packet_parser
// Frames the UART byte stream into 6-byte packets
//   SYNC, A_hi, A_lo, B_hi, B_lo, CHK   (CHK = A_hi ^ A_lo ^ B_hi ^ B_lo)
// and publishes validated big-endian prices. Bad or stalled packets are
// dropped with an error pulse; the last good prices are held.
//   clk, rst : 50 MHz clock, asynchronous active-high reset
//   bus      : price_packet_parser_if.slave (byte stream in, prices out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module price_packet_parser
    import arb_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    price_packet_parser_if.slave bus
);

    parser_state_t      r_state;
    logic [PRICE_W-1:0] r_shadow_a;
    logic [PRICE_W-1:0] r_shadow_b;
    logic [7:0]         r_chk;
    logic [PRICE_W-1:0] r_price_a;
    logic [PRICE_W-1:0] r_price_b;
    logic               r_packet_valid;
    logic               r_err_checksum;
    logic               r_err_timeout;
    logic [15:0]        r_pkt_count;

    logic               w_timer_en;
    logic               w_expired;

    assign w_timer_en = (r_state != ST_HUNT);

    byte_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (w_timer_en),
        .i_clear   (bus.rx_valid),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_HUNT;
            r_shadow_a     <= '0;
            r_shadow_b     <= '0;
            r_chk          <= '0;
            r_price_a      <= '0;
            r_price_b      <= '0;
            r_packet_valid <= 1'b0;
            r_err_checksum <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_pkt_count    <= '0;
        end else begin
            // Pulses default low each cycle so they last exactly one cycle.
            r_packet_valid <= 1'b0;
            r_err_checksum <= 1'b0;
            r_err_timeout  <= 1'b0;

            if (bus.rx_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            r_chk   <= '0;
                            r_state <= ST_A_HI;
                        end
                    end
                    // Inside a packet every byte is data, including SYNC_BYTE.
                    ST_A_HI: begin
                        r_shadow_a[15:8] <= bus.rx_data;
                        r_chk            <= chk_fold(r_chk, bus.rx_data);
                        r_state          <= ST_A_LO;
                    end
                    ST_A_LO: begin
                        r_shadow_a[7:0] <= bus.rx_data;
                        r_chk           <= chk_fold(r_chk, bus.rx_data);
                        r_state         <= ST_B_HI;
                    end
                    ST_B_HI: begin
                        r_shadow_b[15:8] <= bus.rx_data;
                        r_chk            <= chk_fold(r_chk, bus.rx_data);
                        r_state          <= ST_B_LO;
                    end
                    ST_B_LO: begin
                        r_shadow_b[7:0] <= bus.rx_data;
                        r_chk           <= chk_fold(r_chk, bus.rx_data);
                        r_state         <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (bus.rx_data == r_chk) begin
                            r_price_a      <= r_shadow_a;
                            r_price_b      <= r_shadow_b;
                            r_packet_valid <= 1'b1;
                            r_pkt_count    <= r_pkt_count + 16'd1;
                        end else begin
                            r_err_checksum <= 1'b1;
                        end
                        r_state <= ST_HUNT;
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end else if (w_expired) begin
                r_err_timeout <= 1'b1;
                r_state       <= ST_HUNT;
            end
        end
    end

    assign bus.price_A      = r_price_a;
    assign bus.price_B      = r_price_b;
    assign bus.packet_valid = r_packet_valid;
    assign bus.err_checksum = r_err_checksum;
    assign bus.err_timeout  = r_err_timeout;
    assign bus.pkt_count    = r_pkt_count;

endmodule

// File: tb/tb_price_packet_parser.sv
// -----------------------------------------------------------------------------
// tb_price_packet_parser
// Self-checking bench for price_packet_parser (TIMEOUT_CYCLES = 20).
// Expected pulse events are queued when the closing byte is driven and
// compared by a monitor whenever the DUT raises any pulse.
// -----------------------------------------------------------------------------
module tb_price_packet_parser;

    localparam int TO = 20;

    typedef enum logic [1:0] { EV_GOOD, EV_CHK, EV_TO } ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] cnt;
    } ev_t;

    typedef struct {
        logic [0:8][7:0] bytes;
        int              n;
        logic            good;
        logic [15:0]     exp_a;
        logic [15:0]     exp_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    ev_t         sb_q[$];
    logic [15:0] m_a   = '0;
    logic [15:0] m_b   = '0;
    logic [15:0] m_cnt = '0;

    price_packet_parser_if bus ();

    price_packet_parser #(
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Tasks are entered at a negedge and return at the next negedge.
    task automatic send_byte(input logic [7:0] d);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input ev_kind_t k);
        ev_t e;
        if (k == EV_GOOD) m_cnt = m_cnt + 16'd1;
        e.kind = k;
        e.a    = m_a;
        e.b    = m_b;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
    endtask

    // Drives a packet back-to-back; the expected event is queued before the
    // closing byte is driven.
    task automatic send_vec(input vec_t v);
        for (int j = 0; j < v.n; j++) begin
            if (j == v.n - 1) begin
                if (v.good) begin
                    m_a = v.exp_a;
                    m_b = v.exp_b;
                    expect_ev(EV_GOOD);
                end else begin
                    expect_ev(EV_CHK);
                end
            end
            send_byte(v.bytes[j]);
        end
    endtask

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (bus.packet_valid || bus.err_checksum || bus.err_timeout)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got valid=%0b chk=%0b to=%0b, expected no pulse",
                         bus.packet_valid, bus.err_checksum, bus.err_timeout);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                check("sb_packet_valid", 32'(bus.packet_valid), 32'(e.kind == EV_GOOD));
                check("sb_err_checksum", 32'(bus.err_checksum), 32'(e.kind == EV_CHK));
                check("sb_err_timeout",  32'(bus.err_timeout),  32'(e.kind == EV_TO));
                check("sb_price_A",      32'(bus.price_A),      32'(e.a));
                check("sb_price_B",      32'(bus.price_B),      32'(e.b));
                check("sb_pkt_count",    32'(bus.pkt_count),    32'(e.cnt));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion, expected $finish before 2 ms");
        $fatal(1, "watchdog");
    end

    vec_t vecs[5];

    initial begin
        // {bytes, n, good, price_A, price_B}
        vecs[0] = '{bytes: {8'hAA, 8'h10, 8'hAE, 8'h10, 8'h8B, 8'h25, 8'h00, 8'h00, 8'h00},
                    n: 6, good: 1'b1, exp_a: 16'd4270, exp_b: 16'd4235};
        vecs[1] = '{bytes: {8'hAA, 8'h10, 8'hAE, 8'h10, 8'h8B, 8'h24, 8'h00, 8'h00, 8'h00},
                    n: 6, good: 1'b0, exp_a: 16'd0, exp_b: 16'd0};
        vecs[2] = '{bytes: {8'h00, 8'hFF, 8'h55, 8'hAA, 8'h00, 8'h64, 8'h00, 8'hC8, 8'hAC},
                    n: 9, good: 1'b1, exp_a: 16'd100, exp_b: 16'd200};
        vecs[3] = '{bytes: {8'hAA, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 6, good: 1'b1, exp_a: 16'hAA55, exp_b: 16'hAA55};
        vecs[4] = '{bytes: {8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 8'h00, 8'h00, 8'h00},
                    n: 6, good: 1'b1, exp_a: 16'h1234, exp_b: 16'h5678};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst          = 1'b1;
        idle(3);
        check("rst_price_A",      32'(bus.price_A),      32'd0);
        check("rst_price_B",      32'(bus.price_B),      32'd0);
        check("rst_pkt_count",    32'(bus.pkt_count),    32'd0);
        check("rst_packet_valid", 32'(bus.packet_valid), 32'd0);
        check("rst_err_checksum", 32'(bus.err_checksum), 32'd0);
        check("rst_err_timeout",  32'(bus.err_timeout),  32'd0);
        rst = 1'b0;
        idle(2);

        // Table vectors, driven back-to-back: each sync follows the previous
        // CHK byte on the very next cycle.
        for (int i = 0; i < 5; i++) begin
            send_vec(vecs[i]);
        end
        idle(3);
        check("hold_price_A",   32'(bus.price_A),   32'(m_a));
        check("hold_price_B",   32'(bus.price_B),   32'(m_b));
        check("hold_pkt_count", 32'(bus.pkt_count), 32'(m_cnt));

        // Timeout: AA 10, then a 25-cycle gap. The 20th idle cycle is the
        // expiry cycle; the registered pulse is seen in idle cycle 21.
        send_byte(8'hAA);
        expect_ev(EV_TO);
        send_byte(8'h10);
        for (int k = 1; k <= 25; k++) begin
            check($sformatf("timeout_idle_%0d", k), 32'(bus.err_timeout), 32'(k == TO + 1));
            @(negedge clk);
        end
        check("timeout_price_A", 32'(bus.price_A), 32'(m_a));
        send_vec(vecs[0]);
        idle(2);
        check("after_to_price_A",   32'(bus.price_A),   32'd4270);
        check("after_to_pkt_count", 32'(bus.pkt_count), 32'(m_cnt));

        // Coincidence: the next byte lands exactly on the expiry cycle.
        send_byte(8'hAA);
        send_byte(8'h12);
        idle(TO - 1);
        send_byte(8'h34);
        check("coincide_no_timeout", 32'(bus.err_timeout), 32'd0);
        send_byte(8'h56);
        send_byte(8'h78);
        m_a = 16'h1234;
        m_b = 16'h5678;
        expect_ev(EV_GOOD);
        send_byte(8'h08);
        check("coincide_valid", 32'(bus.packet_valid), 32'd1);
        idle(TO + 5);

        // Long idle in HUNT must not time out (monitor flags any pulse).
        idle(3 * TO);

        // Reset mid-packet: no error pulse, prices cleared, then a good packet.
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'hAE);
        rst = 1'b1;
        m_a   = '0;
        m_b   = '0;
        m_cnt = '0;
        idle(2);
        check("midrst_price_A",   32'(bus.price_A),   32'd0);
        check("midrst_pkt_count", 32'(bus.pkt_count), 32'd0);
        rst = 1'b0;
        idle(TO + 5);
        check("post_rst_price_B",   32'(bus.price_B),   32'd0);
        check("post_rst_err_to",    32'(bus.err_timeout), 32'd0);
        send_vec(vecs[0]);
        idle(2);
        check("post_rst_good_A",     32'(bus.price_A),   32'd4270);
        check("post_rst_good_B",     32'(bus.price_B),   32'd4235);
        check("post_rst_good_count", 32'(bus.pkt_count), 32'd1);

        idle(2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
